memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Arbiter and sequencer for the single byte-wide memory port shared by the instruction cache (miss refills) and the load/store unit. It grants one requester at a time and serialises each access into 1, 2 or 4 consecutive byte cycles. Read bytes are assembled little-endian into a 32-bit word; write words are split little-endian into bytes. It sits between IC/LSB and the external RAM/IO bus and owns all bus drive.

## Interface
- No parameters; all addresses are 32 bits.
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- pause  in  1  global stall; when high, all registers hold and `mem_wr` is forced to 0
- ic_req  in  1  IC miss request (level); held until `ic_ready`
- ic_addr  in  32  IC word address
- ic_data  out  32  fetched instruction word
- ic_ready  out  1  one-cycle completion pulse for IC
- ls_req  in  1  LSB request (level); held until `ls_ready`
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  access size: 0 = byte, 1 = half, 2 or 3 = word
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data; the low bytes are used
- ls_rdata  out  32  load data, zero-extended
- ls_ready  out  1  one-cycle completion pulse for LSB
- io_buffer_full  in  1  IO sink cannot accept a byte
- mem_din  in  8  RAM read data; valid one cycle after the address
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  write strobe

## Operation
- States: IDLE, RD, WR, DONE.
- **Grant, evaluated in IDLE only:**
  - Candidates are the IC when `ic_req` is high, and the LSB when `ls_req` is high and it is not blocked.
  - An LSB request is blocked when it is a store to the IO region (`ls_addr[17:16]==2'b11`) and `io_buffer_full` is high. A blocked store leaves the arbiter free to grant the IC.
  - If both requesters are candidates, grant the one not granted last. The `last_grant` register resets to LSB, so the IC wins the first conflict.
- **On grant:**
  - Latch owner, address, byte count N (IC: N=4; LSB: 1, 2 or 4 from `ls_size`), `ls_we` and `ls_wdata`.
  - Later changes on the request inputs are ignored until DONE.
- **RD:**
  - The edge entering RD drives `mem_a=addr` with `cnt=0`.
  - At edge Ek (k = 1..N), store `mem_din` into byte k-1 of the read buffer.
  - For k < N, also drive `mem_a=addr+k`. At k = N, `mem_a` holds and the state moves to DONE.
- **WR:**
  - The edge entering WR drives `mem_a=addr`, `mem_dout=wdata[7:0]` and `mem_wr=1`.
  - At edge Ek (k < N), drive `addr+k` and `wdata[8k+7:8k]`.
  - At edge EN, `mem_wr` goes to 0 and the state moves to DONE.
- **DONE (exactly one cycle):**
  - Pulse the owner's ready signal.
  - For an IC read, drive `ic_data` from the read buffer. For an LSB load, drive `ls_rdata` from it (bytes above N are 0).
  - No grant is made in DONE. Requesters drop `req` during this cycle. The next state is IDLE.
- `ic_data` and `ls_rdata` hold their value until the next completion for that requester.
- Address increment wraps modulo 2^32. Alignment is not checked.
- **Reset** (priority over pause):
  - The state becomes IDLE and any transaction in flight is aborted with no ready pulse.
  - All outputs go to 0 and `last_grant` becomes LSB.

## Timing
- The grant decision is made at edge E0 from request levels sampled in IDLE.
- Ready is high in the cycle after edge EN: N+1 edges from the request edge, for both reads and writes.
  - Word access, or any IC access: ready after edge E4.
  - Byte access: ready after edge E1.
- Minimum spacing between transactions is N+2 cycles (grant, N data cycles, DONE).
- **Pause** freezes state, counter, `mem_a` and `mem_dout`, and gates `mem_wr`.
  - A paused read keeps `mem_a` stable, so `mem_din` is still valid on the edge that resumes.
  - A paused write does not repeat a byte.
- `io_buffer_full` is checked only at grant. It is not checked during WR, because an IO write is a single byte.

## Test plan
- **IC refill:** with `ic_req` high, `ic_addr=0x100`, RAM[0x100..0x103]=13,05,00,00 → `mem_a` takes 0x100..0x103 on consecutive cycles; `ic_ready` pulses one cycle after edge E4 with `ic_data=0x00000513`.
- **LSB store half:** store with `ls_size=1`, `ls_addr=0x200`, `ls_wdata=0xAABBCCDD` → `mem_wr` high for 2 cycles writing DD@0x200 then CC@0x201; `ls_ready` pulses after edge E2.
- **Simultaneous requests:** both requesters raise `req` after reset → IC is granted first, LSB next; hold both high continuously → grants alternate IC, LSB, IC.
- **IO block:** store to 0x30000 with `io_buffer_full=1` while `ic_req` is high → IC is served and the store waits; drop full → store of one byte, `ls_ready` after E1.
- **Pause mid-read:** assert `pause` for 3 cycles during byte 2 of an LSB word load → `mem_a` holds, the assembled word is correct, and ready latency is extended by exactly 3 cycles.
- **Reset mid-write:** assert `rst` on edge E2 of a word store → the next cycle is IDLE with `mem_wr=0` and no `ls_ready` pulse.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbiter and byte sequencer for the shared byte-wide memory port: grants the instruction
// cache or the load/store unit and serialises each access into 1, 2 or 4 byte cycles.
module memory_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic [31:0] ic_data,
    output logic        ic_ready,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_ready,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    localparam logic OwnerIc = 1'b0;
    localparam logic OwnerLs = 1'b1;

    state_e      state_q;
    logic        owner_q;
    logic        last_grant_q;
    logic [31:0] addr_q;
    logic [2:0]  len_q;
    logic [1:0]  cnt_q;
    logic [23:0] wdata_hi_q;
    logic [31:0] rbuf_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic [31:0] ic_data_q;
    logic [31:0] ls_rdata_q;
    logic        ic_ready_q;
    logic        ls_ready_q;

    logic        ls_blocked;
    logic        ic_cand;
    logic        ls_cand;
    logic        grant_ls;
    logic [2:0]  ls_len;
    logic [2:0]  cnt_next;
    logic        last_beat;
    logic [31:0] next_addr;
    logic [7:0]  wr_byte;
    logic [31:0] rd_word;

    // A store into the IO region cannot start while the IO sink is full.
    assign ls_blocked = ls_we && (ls_addr[17:16] == 2'b11) && io_buffer_full;
    assign ic_cand    = ic_req;
    assign ls_cand    = ls_req && !ls_blocked;
    assign grant_ls   = ls_cand && (!ic_cand || (last_grant_q == OwnerIc));

    assign cnt_next   = {1'b0, cnt_q} + 3'd1;
    assign last_beat  = (cnt_next == len_q);
    assign next_addr  = addr_q + {29'd0, cnt_next};

    always_comb begin
        case (ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    // Byte 0 is driven at grant; this selects byte cnt+1 for the following beats.
    always_comb begin
        case (cnt_q)
            2'd0:    wr_byte = wdata_hi_q[7:0];
            2'd1:    wr_byte = wdata_hi_q[15:8];
            default: wr_byte = wdata_hi_q[23:16];
        endcase
    end

    always_comb begin
        rd_word = rbuf_q;
        case (cnt_q)
            2'd0:    rd_word[7:0]   = mem_din;
            2'd1:    rd_word[15:8]  = mem_din;
            2'd2:    rd_word[23:16] = mem_din;
            default: rd_word[31:24] = mem_din;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnerIc;
            last_grant_q <= OwnerLs;
            addr_q       <= 32'd0;
            len_q        <= 3'd0;
            cnt_q        <= 2'd0;
            wdata_hi_q   <= 24'd0;
            rbuf_q       <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            ic_data_q    <= 32'd0;
            ls_rdata_q   <= 32'd0;
            ic_ready_q   <= 1'b0;
            ls_ready_q   <= 1'b0;
        end else if (!pause) begin
            ic_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ic_cand || ls_cand) begin
                        owner_q      <= grant_ls;
                        last_grant_q <= grant_ls;
                        cnt_q        <= 2'd0;
                        rbuf_q       <= 32'd0;
                        if (grant_ls) begin
                            addr_q     <= ls_addr;
                            len_q      <= ls_len;
                            wdata_hi_q <= ls_wdata[31:8];
                            mem_a_q    <= ls_addr;
                            mem_dout_q <= ls_wdata[7:0];
                            mem_wr_q   <= ls_we;
                            state_q    <= ls_we ? StWr : StRd;
                        end else begin
                            addr_q  <= ic_addr;
                            len_q   <= 3'd4;
                            mem_a_q <= ic_addr;
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    rbuf_q <= rd_word;
                    if (last_beat) begin
                        state_q <= StDone;
                        if (owner_q == OwnerLs) begin
                            ls_rdata_q <= rd_word;
                            ls_ready_q <= 1'b1;
                        end else begin
                            ic_data_q  <= rd_word;
                            ic_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_next[1:0];
                        mem_a_q <= next_addr;
                    end
                end
                StWr: begin
                    if (last_beat) begin
                        mem_wr_q <= 1'b0;
                        state_q  <= StDone;
                        if (owner_q == OwnerLs) begin
                            ls_ready_q <= 1'b1;
                        end else begin
                            ic_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q      <= cnt_next[1:0];
                        mem_a_q    <= next_addr;
                        mem_dout_q <= wr_byte;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ic_data  = ic_data_q;
    assign ic_ready = ic_ready_q;
    assign ls_rdata = ls_rdata_q;
    assign ls_ready = ls_ready_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    // The strobe is gated so a stalled write beat is never committed twice.
    assign mem_wr   = mem_wr_q && !pause;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then randomized transactions checked against a
// byte-array RAM and per-transaction expectations derived from the access rules.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_data;
    logic        ic_ready;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ready;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [4096];
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    logic [31:0] exp_ic;
    logic [31:0] exp_ls;
    int          n_checks = 0;
    int          n_fail = 0;

    memory_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .pause          (pause),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_data        (ic_data),
        .ic_ready       (ic_ready),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_rdata       (ls_rdata),
        .ls_ready       (ls_ready),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk = ~clk;

    // Asynchronous-read RAM: data follows the address within the same cycle.
    assign mem_din = ram[mem_a[11:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Commit whatever byte is strobed into the coming edge, then advance one cycle.
    task automatic step();
        if (mem_wr === 1'b1) begin
            wlog_a.push_back(mem_a);
            wlog_d.push_back(mem_dout);
            ram[mem_a[11:0]] = mem_dout;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] addr, input int n);
        logic [31:0] w;
        logic [31:0] a;
        w = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            w = w | ({24'd0, ram[a[11:0]]} << (8 * i));
        end
        return w;
    endfunction

    // pmode: 0 no pause, 1 random pause, 2 three-cycle pause after the second edge.
    task automatic run_txn(input bit is_ic, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int pmode);
        int          n;
        int          u;
        int          np;
        int          edges;
        int          off;
        bit          done;
        bit          pv;
        logic [31:0] expw;
        logic [31:0] a;
        n = is_ic ? 4 : ((size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4));
        expw = ram_word(addr, n);
        wlog_a.delete();
        wlog_d.delete();
        if (is_ic) begin
            ic_req  = 1'b1;
            ic_addr = addr;
        end else begin
            ls_req   = 1'b1;
            ls_we    = we;
            ls_size  = size;
            ls_addr  = addr;
            ls_wdata = wdata;
        end
        u = 0; np = 0; edges = 0; done = 1'b0;
        while (!done && edges < 200) begin
            pv = pause;
            step();
            edges++;
            if (pv) np++;
            else u++;
            if (u >= 1) begin
                off = (u - 1 < n - 1) ? u - 1 : n - 1;
                chk("mem_a", mem_a, addr + 32'(off));
            end
            chk("mem_wr", {31'd0, mem_wr},
                {31'd0, (!is_ic && we && u >= 1 && u <= n && !pause)});
            if (is_ic) begin
                chk("ic_ready", {31'd0, ic_ready}, {31'd0, (u == n + 1)});
                chk("ls_ready_idle", {31'd0, ls_ready}, 32'd0);
            end else begin
                chk("ls_ready", {31'd0, ls_ready}, {31'd0, (u == n + 1)});
                chk("ic_ready_idle", {31'd0, ic_ready}, 32'd0);
            end
            if (u == n + 1) done = 1'b1;
            else if (pmode == 1) pause = ($urandom_range(0, 3) == 0);
            else if (pmode == 2) pause = (u >= 2 && np < 3);
            else pause = 1'b0;
        end
        pause = 1'b0;
        if (is_ic) exp_ic = expw;
        else if (!we) exp_ls = expw;
        chk("ic_data", ic_data, exp_ic);
        chk("ls_rdata", ls_rdata, exp_ls);
        chk("wr_count", 32'(wlog_a.size()), (!is_ic && we) ? 32'(n) : 32'd0);
        for (int i = 0; i < wlog_a.size() && i < n; i++) begin
            a = wdata >> (8 * i);
            chk("wr_addr", wlog_a[i], addr + 32'(i));
            chk("wr_data", {24'd0, wlog_d[i]}, {24'd0, a[7:0]});
        end
        if (is_ic) ic_req = 1'b0;
        else ls_req = 1'b0;
        step();
        chk("ready_pulse", {30'd0, ic_ready, ls_ready}, 32'd0);
    endtask

    initial begin
        int          ev [3];
        int          nev;
        int          edges;
        logic [31:0] e_ic;
        logic [31:0] e_ls;
        bit          r_ic;
        bit          r_we;
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        rst = 1'b1; pause = 1'b0; io_buffer_full = 1'b0;
        ic_req = 1'b0; ic_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        exp_ic = 32'd0; exp_ls = 32'd0;
        step();
        step();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_ic_ready", {31'd0, ic_ready}, 32'd0);
        chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
        chk("rst_ic_data", ic_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst = 1'b0;

        // Both requesters held high: IC first, then alternate.
        ic_req = 1'b1; ic_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h310;
        e_ic = ram_word(32'h300, 4);
        e_ls = ram_word(32'h310, 1);
        for (int i = 0; i < 3; i++) ev[i] = 2;
        nev = 0; edges = 0;
        while (nev < 3 && edges < 60) begin
            step();
            edges++;
            chk("alt_one_ready", {31'd0, ic_ready & ls_ready}, 32'd0);
            if (ic_ready === 1'b1) begin
                ev[nev] = 0; nev++; exp_ic = e_ic;
                chk("alt_ic_data", ic_data, exp_ic);
            end else if (ls_ready === 1'b1) begin
                ev[nev] = 1; nev++; exp_ls = e_ls;
                chk("alt_ls_rdata", ls_rdata, exp_ls);
            end
        end
        ic_req = 1'b0; ls_req = 1'b0;
        step();
        chk("alt_count", 32'(nev), 32'd3);
        chk("alt_latency", 32'(edges), 32'd14);
        chk("alt_first_ic", 32'(ev[0]), 32'd0);
        chk("alt_second_ls", 32'(ev[1]), 32'd1);
        chk("alt_third_ic", 32'(ev[2]), 32'd0);

        // IC refill of a known instruction.
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        run_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, 0);
        chk("ic_refill_word", ic_data, 32'h0000_0513);

        run_txn(1'b0, 1'b1, 2'd1, 32'h200, 32'hAABB_CCDD, 0);
        chk("store_half_b0", {24'd0, ram[12'h200]}, 32'hDD);
        chk("store_half_b1", {24'd0, ram[12'h201]}, 32'hCC);

        // IO store blocked by a full sink; IC proceeds, store waits.
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000;
        ls_wdata = 32'h0000_005A;
        run_txn(1'b1, 1'b0, 2'd0, 32'h120, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("io_wait_wr", {31'd0, mem_wr}, 32'd0);
            chk("io_wait_ready", {31'd0, ls_ready}, 32'd0);
        end
        io_buffer_full = 1'b0;
        run_txn(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A, 0);

        run_txn(1'b0, 1'b0, 2'd2, 32'h400, 32'd0, 2);

        // Reset on the second data edge of a word store.
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'h1122_3344;
        step();
        step();
        chk("rstw_wr_active", {31'd0, mem_wr}, 32'd1);
        chk("rstw_addr_b1", mem_a, 32'h501);
        rst = 1'b1;
        step();
        rst = 1'b0; ls_req = 1'b0;
        exp_ic = 32'd0; exp_ls = 32'd0;
        chk("rstw_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rstw_mem_a", mem_a, 32'd0);
        chk("rstw_ls_ready", {31'd0, ls_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstw_no_ready", {31'd0, ls_ready}, 32'd0);
            chk("rstw_idle_wr", {31'd0, mem_wr}, 32'd0);
        end

        for (int it = 0; it < 60; it++) begin
            r_ic   = 1'($urandom_range(0, 1));
            r_we   = r_ic ? 1'b0 : 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                 : 32'($urandom);
            run_txn(r_ic, r_we, r_size, r_addr, 32'($urandom), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
